// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//
// Shared definitions for the multi-cycle hazard unit.
//   FWD_NONE / FWD_W / FWD_M : forward-mux select codes driven per source slot
//                              (register file / W-stage result / M-stage result).
//   mc_state_e               : multi-cycle execute FSM states.
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;

    // IDLE : no multi-cycle op in Execute.
    // BUSY : op occupying Execute; pipeline upstream of M is held.
    // DONE : final Execute cycle, result valid, pipeline released.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mc_state_e;

endpackage : hazard_pkg

// File: rtl/hazard_fwd_sel.sv
// -----------------------------------------------------------------------------
// hazard_fwd_sel
//
// Single-slot forwarding comparator / priority encoder. Compares one Execute
// source address against the M and W destination addresses and picks the
// youngest valid producer. The PC register is never forwarded because its
// value comes from the PC+8 path, not from a pipeline result.
//
// Ports
//   i_ra    in  AW  source register address in Execute
//   i_wa_m  in  AW  destination address in Memory
//   i_we_m  in  1   Memory destination valid
//   i_wa_w  in  AW  destination address in Writeback
//   i_we_w  in  1   Writeback destination valid
//   o_sel   out 2   FWD_M, FWD_W or FWD_NONE
// -----------------------------------------------------------------------------
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int AW     = 4,
    parameter int PC_REG = 15
) (
    input  logic [AW-1:0] i_ra,
    input  logic [AW-1:0] i_wa_m,
    input  logic          i_we_m,
    input  logic [AW-1:0] i_wa_w,
    input  logic          i_we_w,
    output logic [1:0]    o_sel
);

    localparam logic [AW-1:0] PC_ADDR = AW'(PC_REG);

    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        o_sel = FWD_NONE;
        if (i_ra != PC_ADDR) begin
            // M holds the younger result, so it wins over W.
            if (i_we_m && (i_ra == i_wa_m)) begin
                o_sel = FWD_M;
            end else if (i_we_w && (i_ra == i_wa_w)) begin
                o_sel = FWD_W;
            end
        end
    end

endmodule : hazard_fwd_sel

// File: rtl/hazard_unit_mc.sv
// -----------------------------------------------------------------------------
// hazard_unit_mc
//
// Hazard unit for the 5-stage (F/D/E/M/W) datapath. Generates per-source
// result and base-writeback forward selects, detects load-use hazards,
// stalls the front of the pipeline while a multi-cycle execute op (MUL/DIV)
// occupies Execute, and keeps a saturating count of front-end stall cycles.
//
// Parameters
//   NUM_SRC  source operands per instruction
//   AW       register address width
//   MC_LAT   Execute cycles of a multi-cycle op (>= 2)
//   PC_REG   register number that is never forwarded
//   CNT_W    stall counter width
//
// Ports
//   clk, reset                    clock (rising edge), async active-high reset
//   RA_D, RA_E                    NUM_SRC packed source addresses (slot i at [i*AW +: AW])
//   WA3E/M/W, RegWriteE/M/W       destination address and valid per stage
//   WBAddrM/W, WriteBackM/W       base-register writeback address and valid
//   MemtoRegE, MemWriteE          Execute load / store flags
//   MultiStartE                   multi-cycle op valid in Execute
//   BranchMissedE, PCSrcW,
//   PCWrPendingF                  control-flow events
//   StatClr                       synchronous clear of StallCount
//   ForwardE, ForwardIdxE         2-bit selects per slot
//   StallF/D/E                    stage-register hold
//   FlushD/E/M                    stage-register clear
//   MultiDoneE                    single-cycle pulse, multi-cycle result valid
//   StallCount                    saturating count of cycles with StallF=1
// -----------------------------------------------------------------------------
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int AW      = 4,
    parameter int MC_LAT  = 4,
    parameter int PC_REG  = 15,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic [NUM_SRC*AW-1:0]  RA_D,
    input  logic [NUM_SRC*AW-1:0]  RA_E,
    input  logic [AW-1:0]          WA3E,
    input  logic [AW-1:0]          WA3M,
    input  logic [AW-1:0]          WA3W,
    input  logic                   RegWriteE,
    input  logic                   RegWriteM,
    input  logic                   RegWriteW,
    input  logic [AW-1:0]          WBAddrM,
    input  logic [AW-1:0]          WBAddrW,
    input  logic                   WriteBackM,
    input  logic                   WriteBackW,
    input  logic                   MemtoRegE,
    input  logic                   MemWriteE,
    input  logic                   MultiStartE,
    input  logic                   BranchMissedE,
    input  logic                   PCSrcW,
    input  logic                   PCWrPendingF,
    input  logic                   StatClr,

    output logic [NUM_SRC*2-1:0]   ForwardE,
    output logic [NUM_SRC*2-1:0]   ForwardIdxE,
    output logic                   StallF,
    output logic                   StallD,
    output logic                   StallE,
    output logic                   FlushD,
    output logic                   FlushE,
    output logic                   FlushM,
    output logic                   MultiDoneE,
    output logic [CNT_W-1:0]       StallCount
);

    localparam logic [AW-1:0] PC_ADDR = AW'(PC_REG);

    // Latency counter only has to hold MC_LAT-2.
    localparam int             LW       = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
    localparam logic [LW-1:0]  LAT_LOAD = LW'(MC_LAT - 2);

    // -------------------------------------------------------------------------
    // Forwarding: one result selector and one base-writeback selector per slot.
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
        hazard_fwd_sel #(
            .AW     (AW),
            .PC_REG (PC_REG)
        ) u_fwd_res (
            .i_ra   (RA_E[g*AW +: AW]),
            .i_wa_m (WA3M),
            .i_we_m (RegWriteM),
            .i_wa_w (WA3W),
            .i_we_w (RegWriteW),
            .o_sel  (ForwardE[g*2 +: 2])
        );

        hazard_fwd_sel #(
            .AW     (AW),
            .PC_REG (PC_REG)
        ) u_fwd_idx (
            .i_ra   (RA_E[g*AW +: AW]),
            .i_wa_m (WBAddrM),
            .i_we_m (WriteBackM),
            .i_wa_w (WBAddrW),
            .i_we_w (WriteBackW),
            .o_sel  (ForwardIdxE[g*2 +: 2])
        );
    end

    // -------------------------------------------------------------------------
    // Load-use detection: a load in Execute whose destination is read by any
    // Decode source must hold Decode for one cycle. A store never writes a
    // register, and the PC is never a real load destination for forwarding.
    // -------------------------------------------------------------------------
    logic w_ra_d_hit;
    logic w_ldr_stall;

    always_comb begin
        w_ra_d_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (RA_D[i*AW +: AW] == WA3E) begin
                w_ra_d_hit = 1'b1;
            end
        end
    end

    assign w_ldr_stall = MemtoRegE & ~MemWriteE & RegWriteE & w_ra_d_hit &
                         (WA3E != PC_ADDR);

    // -------------------------------------------------------------------------
    // Multi-cycle execute FSM.
    // The start cycle itself is already a busy cycle (state still IDLE), then
    // BUSY lasts MC_LAT-2 cycles and DONE is the last Execute cycle, giving
    // MC_LAT cycles of Execute occupancy in total.
    // -------------------------------------------------------------------------
    mc_state_e         r_state;
    mc_state_e         w_state_nxt;
    logic [LW-1:0]     r_cnt;
    logic [LW-1:0]     w_cnt_nxt;
    logic              w_busy;
    logic              w_multi_done;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_busy       = 1'b0;
        w_multi_done = 1'b0;

        case (r_state)
            IDLE: begin
                // A mispredicted branch squashes the op, so it never starts.
                if (MultiStartE && !BranchMissedE) begin
                    w_busy    = 1'b1;
                    w_cnt_nxt = LAT_LOAD;
                    // With MC_LAT==2 there are no BUSY cycles at all.
                    w_state_nxt = (MC_LAT > 2) ? BUSY : DONE;
                end
            end

            BUSY: begin
                w_busy    = 1'b1;
                w_cnt_nxt = r_cnt - 1'b1;
                if (w_cnt_nxt == '0) begin
                    w_state_nxt = DONE;
                end
            end

            DONE: begin
                // A new MultiStartE here belongs to the stalled-and-released
                // op itself, so it is deliberately ignored.
                w_multi_done = 1'b1;
                w_state_nxt  = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Stall / flush equations. Control-flow flushes wait until the multi-cycle
    // op releases the pipeline; the requester holds its event until then.
    // -------------------------------------------------------------------------
    assign StallE     = w_busy;
    assign FlushM     = w_busy;
    assign StallD     = w_ldr_stall | w_busy;
    assign StallF     = w_ldr_stall | w_busy | PCWrPendingF;
    assign FlushE     = w_ldr_stall & ~w_busy;
    assign FlushD     = (PCWrPendingF | PCSrcW | BranchMissedE) & ~w_busy;
    assign MultiDoneE = w_multi_done;

    // -------------------------------------------------------------------------
    // Saturating stall-cycle statistics counter. Clear beats increment.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (StatClr) begin
            r_stall_cnt <= '0;
        end else if (StallF && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign StallCount = r_stall_cnt;

endmodule : hazard_unit_mc
